// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode feeding a single-entry
// valid/ready pipeline register. Shared enums live in definitions_pkg.

package definitions_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_e;

  typedef enum logic [2:0] {
    IMM_I_TYPE = 3'd0,
    IMM_STORE  = 3'd1,
    IMM_BRANCH = 3'd2,
    IMM_JAL    = 3'd3,
    IMM_U_TYPE = 3'd4
  } imm_e;
endpackage

// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready = !out_valid || out_ready, so the register accepts
// whenever it is empty or its current bundle retires on the same edge.
// While out_valid && !out_ready every output holds. flush wins over any
// accept on the same edge and empties the register.
module decode_stage
  import definitions_pkg::*;
#(
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output alu_e        out_alu_op,
  output imm_e        out_imm_sel,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_alu_src_imm,
  output logic        out_reg_write,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Base ALU op selected by funct3 for OP / OP-IMM (SUB/SRA handled by caller)
  function automatic alu_e f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_op = ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  alu_e        d_alu_op;
  imm_e        d_imm_sel;
  logic [31:0] d_imm;
  logic [4:0]  d_rs1;
  logic        d_alu_src_imm;
  logic        d_reg_write;
  logic        d_illegal;
  logic        bad;
  logic        load;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rd_field = in_instr[11:7];

  // Opcode/funct decode; an unsupported encoding falls back to a harmless ADD
  always_comb begin
    d_alu_op      = ALU_ADD;
    d_imm_sel     = IMM_I_TYPE;
    d_alu_src_imm = 1'b0;
    d_reg_write   = 1'b0;
    d_rs1         = in_instr[19:15];
    bad           = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          d_imm_sel = IMM_U_TYPE; d_alu_src_imm = 1'b1; d_reg_write = 1'b1;
          d_rs1 = 5'd0;
        end
        OPC_AUIPC: begin
          d_imm_sel = IMM_U_TYPE; d_alu_src_imm = 1'b1; d_reg_write = 1'b1;
        end
        OPC_JAL: begin
          d_imm_sel = IMM_JAL; d_alu_src_imm = 1'b1; d_reg_write = 1'b1;
        end
        OPC_JALR: begin
          d_alu_src_imm = 1'b1; d_reg_write = 1'b1;
          bad = (funct3 != 3'b000);
        end
        OPC_BRANCH: begin
          d_imm_sel = IMM_BRANCH;
          case (funct3)
            3'b000, 3'b001: d_alu_op = ALU_SUB;
            3'b100, 3'b101: d_alu_op = ALU_SLT;
            3'b110, 3'b111: d_alu_op = ALU_SLTU;
            default:        bad = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          d_alu_src_imm = 1'b1; d_reg_write = 1'b1;
          bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        OPC_STORE: begin
          d_imm_sel = IMM_STORE; d_alu_src_imm = 1'b1;
          bad = (funct3 >= 3'b011);
        end
        OPC_OP_IMM: begin
          d_alu_src_imm = 1'b1; d_reg_write = 1'b1;
          d_alu_op = f3_op(funct3);
          if (funct3 == 3'b001) begin
            bad = (funct7 != 7'd0);
          end else if (funct3 == 3'b101) begin
            if (funct7 == F7_ALT) d_alu_op = ALU_SRA;
            else bad = (funct7 != 7'd0);
          end
        end
        OPC_OP: begin
          d_reg_write = 1'b1;
          if (funct7 == 7'd0)                          d_alu_op = f3_op(funct3);
          else if (funct7 == F7_ALT && funct3 == 3'b000) d_alu_op = ALU_SUB;
          else if (funct7 == F7_ALT && funct3 == 3'b101) d_alu_op = ALU_SRA;
          else                                           bad = 1'b1;
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      d_alu_op      = ALU_ADD;
      d_imm_sel     = IMM_I_TYPE;
      d_alu_src_imm = 1'b0;
      d_reg_write   = 1'b0;
    end
    if (rd_field == 5'd0) d_reg_write = 1'b0;
    d_illegal = CHECK_ILLEGAL ? bad : 1'b0;
  end

  // Immediate assembly for the selected format
  always_comb begin
    d_imm = {{20{in_instr[31]}}, in_instr[31:20]};
    case (d_imm_sel)
      IMM_STORE:  d_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_BRANCH: d_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_JAL:    d_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
      IMM_U_TYPE: d_imm = {in_instr[31:12], 12'b0};
      default:    d_imm = {{20{in_instr[31]}}, in_instr[31:20]};
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Valid bit: flush empties, accept fills, retirement without refill empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   out_valid <= 1'b0;
    else if (flush)               out_valid <= 1'b0;
    else if (load)                out_valid <= 1'b1;
    else if (out_ready)           out_valid <= 1'b0;
  end

  // Payload register: captured only on accept, otherwise held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc          <= '0;
      out_alu_op      <= ALU_ADD;
      out_imm_sel     <= IMM_I_TYPE;
      out_imm         <= '0;
      out_rs1         <= '0;
      out_rs2         <= '0;
      out_rd          <= '0;
      out_alu_src_imm <= 1'b0;
      out_reg_write   <= 1'b0;
      out_illegal     <= 1'b0;
    end else if (load) begin
      out_pc          <= in_pc;
      out_alu_op      <= d_alu_op;
      out_imm_sel     <= d_imm_sel;
      out_imm         <= d_imm;
      out_rs1         <= d_rs1;
      out_rs2         <= in_instr[24:20];
      out_rd          <= rd_field;
      out_alu_src_imm <= d_alu_src_imm;
      out_reg_write   <= d_reg_write;
      out_illegal     <= d_illegal;
    end
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
Parameters
REQ-001 CHECK_ILLEGAL, default 1: when 1, unsupported encodings raise out_illegal; when 0, out_illegal is tied 0 and those encodings decode as ALU_ADD, no register write.

Ports (alu_e and imm_e are from definitions_pkg)
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  upstream instruction valid.
REQ-005 in_ready  out  1  stage can accept an instruction this cycle.
REQ-006 in_instr  in  32  RV32I instruction word.
REQ-007 in_pc  in  32  PC of in_instr.
REQ-008 flush  in  1  discard held and incoming instruction.
REQ-009 out_valid  out  1  decoded bundle valid.
REQ-010 out_ready  in  1  downstream accepts bundle.
REQ-011 out_pc  out  32  registered in_pc.
REQ-012 out_alu_op  out  alu_e  ALU operation.
REQ-013 out_imm_sel  out  imm_e  immediate format.
REQ-014 out_imm  out  32  sign-extended immediate per out_imm_sel.
REQ-015 out_rs1, out_rs2, out_rd  out  5 each  register indices.
REQ-016 out_alu_src_imm  out  1  ALU operand B is out_imm, not rs2.
REQ-017 out_reg_write  out  1  instruction writes rd; forced 0 when rd==0.
REQ-018 out_illegal  out  1  unsupported encoding.

Function
REQ-019 The stage SHALL be a single-entry pipeline register with combinational decode ahead of it; latency is 1 cycle from input to output.
REQ-020 in_ready SHALL equal !out_valid || out_ready, so back-to-back transfers sustain 1 per cycle.
REQ-021 On in_valid && in_ready, the stage SHALL load the decoded bundle and set out_valid=1. When out_valid && out_ready and no new load occurs, out_valid SHALL clear.
REQ-022 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-023 flush SHALL clear out_valid next cycle and block loading in the same cycle, overriding simultaneous accept/handshake. The payload register is don't-care afterwards.
REQ-024 Opcode mapping (alu_op / imm_sel / alu_src_imm / reg_write):
- LUI: ADD / U_TYPE / 1 / 1; out_rs1 forced 0.
- AUIPC: ADD / U_TYPE / 1 / 1.
- JAL: ADD / JAL / 1 / 1.
- JALR: ADD / I_TYPE / 1 / 1.
- BRANCH: SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU / BRANCH / 0 / 0.
- LOAD: ADD / I_TYPE / 1 / 1.
- STORE: ADD / STORE / 1 / 0.
- OP-IMM: funct3 selects op / I_TYPE / 1 / 1.
- OP: funct3+funct7 select op / I_TYPE (unused) / 0 / 1.
REQ-025 OP: funct7=0100000 selects SUB (funct3=000) or SRA (funct3=101). Any other non-zero funct7 SHALL be illegal.
REQ-026 OP-IMM shifts: imm[11:5]=0100000 selects SRA for funct3=101. Any other non-zero imm[11:5] on SLLI/SRLI/SRAI SHALL be illegal. OP-IMM never yields SUB.
REQ-027 Immediates SHALL be built as follows:
- I: sext(instr[31:20]).
- S: sext({[31:25],[11:7]}).
- B: sext({[31],[7],[30:25],[11:8],0}).
- J: sext({[31],[19:12],[20],[30:21],0}).
- U: {[31:12],12'b0}.
REQ-028 The following encodings SHALL be illegal:
- unknown opcode;
- instr[1:0]!=11;
- BRANCH funct3 010/011;
- LOAD funct3 011/110/111;
- STORE funct3 >=011;
- JALR funct3!=000.
REQ-029 An illegal instruction SHALL still transfer with out_illegal=1, out_reg_write=0, out_alu_op=ALU_ADD, out_imm_sel=IMM_I_TYPE.
REQ-030 The rs1/rs2/rd fields SHALL always be taken from instr[19:15]/[24:20]/[11:7], except for REQ-024 LUI.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously set out_valid=0 and all payload outputs to 0 (alu_op=ALU_ADD, imm_sel=IMM_I_TYPE). in_ready SHALL read 1.
REQ-032 Reset mid-transfer SHALL drop the held bundle. The first accept after release SHALL occur on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- 0x40B50533 (sub a0,a0,a1), out_ready=1 -> next cycle out_valid=1, alu_op=ALU_SUB, rs1=10, rs2=11, rd=10, reg_write=1, alu_src_imm=0.
- 0xFFF50513 (addi a0,a0,-1) -> imm=0xFFFFFFFF, imm_sel=IMM_I_TYPE, alu_op=ALU_ADD, alu_src_imm=1.
- 0xFE000EE3 (beq x0,x0,-4) -> alu_op=ALU_SUB, imm_sel=IMM_BRANCH, imm=0xFFFFFFFC, reg_write=0.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> bundle retires and next instruction loads same edge.
- 0x02B50533 (mul) with CHECK_ILLEGAL=1 -> out_illegal=1, reg_write=0; flush asserted same cycle as accept -> out_valid=0 next cycle.
- rst_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0 immediately, no bundle emitted.
